mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle for the 3-way memory arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  req_we;
    logic [47:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [1:0]  owner;

    modport slave (
        input  req, lock, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, ack, rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output req, lock, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, ack, rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory port among 3 requesters.
// Latency: ACC one cycle after req, ack one cycle later; locked bursts capped at BURST_MAX.
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [4:0] BMAX   = 5'(BURST_MAX);

    logic [1:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  burst_q, burst_d;
    logic        we_q;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        found;
    logic [4:0]  burst_inc;
    logic [15:0] own_addr, own_wdata;
    logic        own_we, own_req, own_lock;
    logic [2:0]  own_onehot;

    always_comb begin
        own_addr  = 16'h0;
        own_wdata = 16'h0;
        own_we    = 1'b0;
        own_req   = 1'b0;
        own_lock  = 1'b0;
        case (owner_q)
            2'd0: begin
                own_addr  = bus.req_addr[15:0];
                own_wdata = bus.req_wdata[15:0];
                own_we    = bus.req_we[0];
                own_req   = bus.req[0];
                own_lock  = bus.lock[0];
            end
            2'd1: begin
                own_addr  = bus.req_addr[31:16];
                own_wdata = bus.req_wdata[31:16];
                own_we    = bus.req_we[1];
                own_req   = bus.req[1];
                own_lock  = bus.lock[1];
            end
            2'd2: begin
                own_addr  = bus.req_addr[47:32];
                own_wdata = bus.req_wdata[47:32];
                own_we    = bus.req_we[2];
                own_req   = bus.req[2];
                own_lock  = bus.lock[2];
            end
            default: ;
        endcase
    end

    // Round-robin scan starting just past the last owner.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        cand  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        burst_d   = burst_q;
        burst_inc = {1'b0, burst_q} + 5'd1;
        case (state_q)
            S_IDLE: begin
                burst_d = 4'd0;
                if (found) begin
                    state_d = S_ACC;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            S_ACC: state_d = S_RSP;
            S_RSP: begin
                burst_d = burst_inc[3:0];
                // Pointer already equals the owner, so a forced release scans others first.
                if (own_lock && own_req && (burst_inc < BMAX)) state_d = S_ACC;
                else                                          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            burst_q <= 4'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            if (state_q == S_ACC) we_q <= own_we;
        end
    end

    always_comb begin
        own_onehot    = 3'b001 << owner_q;
        bus.gnt       = (state_q != S_IDLE) ? own_onehot : 3'b000;
        bus.ack       = (state_q == S_RSP)  ? own_onehot : 3'b000;
        bus.rdata     = (state_q == S_RSP && !we_q) ? bus.mem_rdata : 16'h0;
        bus.mem_we    = (state_q == S_ACC) ? own_we    : 1'b0;
        bus.mem_addr  = (state_q == S_ACC) ? own_addr  : 16'h0;
        bus.mem_wdata = (state_q == S_ACC) ? own_wdata : 16'h0;
        bus.busy      = (state_q != S_IDLE);
        bus.owner     = owner_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered read-only memory model.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [15:0] mem_rdata_q;

    mem_arbiter_if bus();

    mem_arbiter #(.BURST_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns 0x1234 at 0x0040, otherwise address XOR 0xA5A5, one cycle late.
    always @(posedge clk)
        mem_rdata_q <= (bus.mem_addr == 16'h0040) ? 16'h1234 : (bus.mem_addr ^ 16'hA5A5);
    assign bus.mem_rdata = mem_rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req       = 3'b000;
        bus.lock      = 3'b000;
        bus.req_we    = 3'b000;
        bus.req_addr  = 48'h0;
        bus.req_wdata = 48'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.req = 3'b111;
        #1;
        n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
        n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0)
            begin n_fail++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.ack !== 3'b000 || bus.rdata !== 16'h0)
            begin n_fail++; $display("FAIL reset_ack got ack=%b rdata=%h want 0", bus.ack, bus.rdata); end
        tick();
        n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_hold_gnt got %b want 000", bus.gnt); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL release_no_early_gnt got %b want 000", bus.gnt); end
        tick();
        n_checks++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL first_gnt got %b want 001", bus.gnt); end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.req      = 3'b001;
        bus.req_addr = {16'h0, 16'h0, 16'h0040};
        tick();
        n_checks++; if (bus.mem_addr !== 16'h0040) begin n_fail++; $display("FAIL read_addr got %h want 0040", bus.mem_addr); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL read_we got %b want 0", bus.mem_we); end
        n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL read_early_ack got %b want 000", bus.ack); end
        tick();
        n_checks++; if (bus.ack !== 3'b001) begin n_fail++; $display("FAIL read_ack got %b want 001", bus.ack); end
        n_checks++; if (bus.rdata !== 16'h1234) begin n_fail++; $display("FAIL read_rdata got %h want 1234", bus.rdata); end
        clear_inputs();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_c3 got %b want 0", bus.busy); end
        n_checks++; if (bus.rdata !== 16'h0) begin n_fail++; $display("FAIL read_rdata_idle got %h want 0", bus.rdata); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_ack, exp_gnt;
        apply_reset();
        bus.req = 3'b111;
        for (int c = 1; c <= 11; c++) begin
            tick();
            case (c)
                2: exp_ack = 3'b001;
                5: exp_ack = 3'b010;
                8: exp_ack = 3'b100;
                11: exp_ack = 3'b001;
                default: exp_ack = 3'b000;
            endcase
            case (c)
                1, 2: exp_gnt = 3'b001;
                4, 5: exp_gnt = 3'b010;
                7, 8: exp_gnt = 3'b100;
                10, 11: exp_gnt = 3'b001;
                default: exp_gnt = 3'b000;
            endcase
            n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL contend_ack c%0d got %b want %b", c, bus.ack, exp_ack); end
            n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL contend_gnt c%0d got %b want %b", c, bus.gnt, exp_gnt); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_locked_burst();
        logic [2:0] exp_ack, exp_gnt;
        int n_ack1;
        apply_reset();
        n_ack1 = 0;
        bus.req  = 3'b010;
        bus.lock = 3'b011;
        bus.req_addr = {16'h0, 16'h0200, 16'h0300};
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 1) bus.req = 3'b011;
            if (c >= 2 && c <= 16 && (c % 2) == 0) exp_ack = 3'b010;
            else if (c == 19)                     exp_ack = 3'b001;
            else                                  exp_ack = 3'b000;
            if (c <= 16)      exp_gnt = 3'b010;
            else if (c == 17) exp_gnt = 3'b000;
            else              exp_gnt = 3'b001;
            if (bus.ack == 3'b010) n_ack1++;
            n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL burst_ack c%0d got %b want %b", c, bus.ack, exp_ack); end
            n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL burst_gnt c%0d got %b want %b", c, bus.gnt, exp_gnt); end
        end
        n_checks++; if (n_ack1 !== 8) begin n_fail++; $display("FAIL burst_count got %0d want 8", n_ack1); end
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        apply_reset();
        bus.req       = 3'b100;
        bus.req_we    = 3'b100;
        bus.req_addr  = {16'h0100, 16'h0, 16'h0};
        bus.req_wdata = {16'hBEEF, 16'h0, 16'h0};
        tick();
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL write_we_c1 got %b want 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 16'hBEEF)
            begin n_fail++; $display("FAIL write_bus got a=%h d=%h want 0100/beef", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL write_gnt got %b want 100", bus.gnt); end
        tick();
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL write_we_c2 got %b want 0", bus.mem_we); end
        n_checks++; if (bus.ack !== 3'b100) begin n_fail++; $display("FAIL write_ack got %b want 100", bus.ack); end
        n_checks++; if (bus.rdata !== 16'h0) begin n_fail++; $display("FAIL write_rdata got %h want 0", bus.rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        bus.req       = 3'b100;
        bus.req_we    = 3'b100;
        bus.req_addr  = {16'h0100, 16'h0, 16'h0};
        bus.req_wdata = {16'hBEEF, 16'h0, 16'h0};
        tick();
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we got %b want 1", bus.mem_we); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b want 0", bus.mem_we); end
        n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL midrst_gnt got %b want 000", bus.gnt); end
        tick();
        n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL midrst_ack got %b want 000", bus.ack); end
        clear_inputs();
        bus.req = 3'b011;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL midrst_regrant got %b want 001", bus.gnt); end
        tick();
        clear_inputs();
        tick();
        apply_reset();
        bus.req = 3'b010;
        tick();
        n_checks++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL postrst_req1 got %b want 010", bus.gnt); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_req_drop();
        apply_reset();
        bus.req      = 3'b001;
        bus.req_addr = {16'h0, 16'h0, 16'h0040};
        tick();
        bus.req = 3'b000;
        tick();
        n_checks++; if (bus.ack !== 3'b001) begin n_fail++; $display("FAIL drop_ack got %b want 001", bus.ack); end
        n_checks++; if (bus.rdata !== 16'h1234) begin n_fail++; $display("FAIL drop_rdata got %h want 1234", bus.rdata); end
        clear_inputs();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %b want 0", bus.busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_locked_burst();
        test_write();
        test_reset_mid_op();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
